seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
- Scheduler that shares one serial "001" Moore pattern detector among N_REQ requesters.
- Each requester offers a WORD_W-bit word with a valid/ready handshake. The block grants one requester at a time, round-robin.
- It serialises the granted word MSB-first into the detector and counts the "001" matches (overlapping allowed) within that word.
- It returns the count tagged with the requester id. Sits between bit-pattern clients and the detector datapath.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WORD_W, 8, bits per request word (>=3)
- ID_W, 2, requester id width, $clog2(N_REQ)
- CNT_W, 4, match-count width, must satisfy 2**CNT_W > WORD_W/3

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester word valid
- req_data  in  N_REQ*WORD_W  words; requester i at bits [i*WORD_W +: WORD_W]
- req_ready  out  N_REQ  one-hot, one-cycle accept pulse
- res_valid  out  1  one-cycle result strobe
- res_id  out  ID_W  id of the requester the result belongs to
- res_count  out  CNT_W  number of "001" matches in the word
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; req_ready=0, res_valid=0, res_id=0, res_count=0, busy=0.
  - RR pointer last_grant=N_REQ-1, so requester 0 has first priority.
  - Shift register, bit counter, match counter and detector state all cleared.
- States: IDLE -> SHIFT -> FLUSH -> REPORT -> IDLE.
- IDLE:
  - If any req_valid, pick g = first valid index after last_grant, wrapping modulo N_REQ.
  - req_ready[g]=1 this cycle (combinational from state and req_valid); all other ready bits are 0.
  - On the edge: capture req_data[g], last_grant<=g, clear detector and match count, bit_cnt<=0, go SHIFT.
  - No valid: stay in IDLE.
- SHIFT, WORD_W cycles:
  - Detector input = shift register MSB; shift left each cycle; bit_cnt increments.
  - If detector output=1 this cycle, match count +1.
  - Detector output lags its input by one cycle (Moore), so the SHIFT cycle k count reflects bits 0..k-1.
  - After bit_cnt reaches WORD_W-1, go FLUSH.
- FLUSH, 1 cycle: no new bit; count +1 if detector output=1, which covers a match ending on the last bit. Go REPORT.
- REPORT, 1 cycle:
  - res_valid=1, res_id=g, res_count=final count, all registered. Go IDLE.
  - No result backpressure.
  - res_id and res_count hold their values until the next REPORT; res_valid is 0 outside REPORT.
- Latency and throughput:
  - Ready pulse in cycle T gives res_valid in cycle T+WORD_W+2.
  - Back-to-back grants are spaced WORD_W+3 cycles apart.
- Detector matching:
  - Detects the bit sequence 0,0,1 in time order. Overlap follows Moore state semantics: "001001" gives 2.
  - Detector is cleared at every grant, so matches never span words.
- Request handling:
  - req_valid may drop before grant with no effect.
  - Requests arriving while busy wait; req_ready is 0 whenever busy=1.
- Reset mid-operation:
  - Immediate abort; no res_valid is produced.
  - The accepted word is lost. A requester must re-present it.
  - last_grant returns to N_REQ-1.
- Count arithmetic: unsigned, CNT_W bits; the parameter rule guarantees no overflow.

Decomposition:
- Shared package seq_det_pkg: state encoding typedef (IDLE, SHIFT, FLUSH, REPORT); pattern constant 3'b001.
- One sub-module, det001_moore: the 3-bit Moore detector.
  - Ports: clk, rst, clr (synchronous clear), in, out.
  - out is a function of state only.
- Round-robin pick logic is a function inside seq_det_sched.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=4'hF -> req_ready=0, res_valid=0, busy=0; first grant after release is requester 0.
- Single request, requester 2, data 8'b0010_0100, ready pulse at T -> res_valid only at T+10, res_id=2, res_count=2, busy high T+1..T+10.
- Last-bit boundary: data 8'b1111_1001 -> res_count=1, proving FLUSH counts the final match; data 8'h00 -> res_count=0.
- Round-robin: req_valid=4'hF held continuously -> ready pulses one-hot in order 0,1,2,3,0, each 11 cycles apart; res_id sequence matches.
- No cross-word match: requester 1 sends 8'b1111_1100 then 8'b1111_1111 -> both res_count=0.
- Reset mid-SHIFT: rst=0 at T+4 -> busy=0 and outputs cleared asynchronously, no res_valid; after release with req_valid=4'b1010, next grant is requester 1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the "001" detector scheduler.
package seq_det_pkg;

  // Scheduler phases: wait for a request, shift the word out, drain the
  // detector's one-cycle lag, then publish the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Bit pattern matched by the detector, oldest bit in the MSB.
  localparam logic [2:0] PATTERN = 3'b001;

  // Detector history after a clear. All ones has no suffix that is a prefix
  // of "001", so a fresh word starts with no partial match.
  localparam logic [2:0] HIST_CLEAR = 3'b111;

endpackage

// File: rtl/seq_det_sched_det001_moore.sv
// Three-bit Moore detector for the serial pattern 0,0,1.
// The state is the history of the last three input bits. The output is a
// function of that state only, so a match shows one cycle after its last bit.
module det001_moore
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in,
  output logic out
);

  logic [2:0] hist_reg;

  // Shift history; a synchronous clear discards any partial match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= HIST_CLEAR;
    end else if (clr) begin
      hist_reg <= HIST_CLEAR;
    end else begin
      hist_reg <= {hist_reg[1:0], in};
    end
  end

  assign out = (hist_reg == PATTERN);

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler that shares one serial "001" detector among
// N_REQ requesters. Each granted word is shifted MSB-first through the
// detector. The match count is returned, tagged with the requester id.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int ID_W   = $clog2(N_REQ),
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  output logic [ID_W-1:0]         res_id,
  output logic [CNT_W-1:0]        res_count,
  output logic                    busy
);

  // Wide enough to hold WORD_W itself.
  localparam int BC_W = $clog2(WORD_W + 1);

  state_t              state_reg;
  state_t              state_next;
  logic [ID_W-1:0]     last_grant_reg;
  logic [ID_W-1:0]     grant;
  logic                any_valid;
  logic [WORD_W-1:0]   shift_reg;
  logic [BC_W-1:0]     bit_cnt_reg;
  logic [CNT_W-1:0]    match_cnt_reg;
  logic                res_valid_reg;
  logic [ID_W-1:0]     res_id_reg;
  logic [CNT_W-1:0]    res_count_reg;
  logic                det_clr;
  logic                det_out;

  // First valid requester strictly after 'last', wrapping modulo N_REQ.
  // The scan runs from farthest to nearest so the nearest valid one wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign any_valid = |req_valid;
  assign grant     = rr_pick(req_valid, last_grant_reg);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next state, grant pulse and detector clear.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    det_clr    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          state_next = SHIFT;
          det_clr    = 1'b1;
          // Ready must stay low while reset is held, even in IDLE.
          if (rst) req_ready[grant] = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_reg == BC_W'(WORD_W - 1)) state_next = FLUSH;
      end
      FLUSH:   state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Word capture, serialisation, match counting and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= ID_W'(N_REQ - 1);
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      match_cnt_reg  <= '0;
      res_valid_reg  <= 1'b0;
      res_id_reg     <= '0;
      res_count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            shift_reg      <= req_data[grant*WORD_W +: WORD_W];
            last_grant_reg <= grant;
            bit_cnt_reg    <= '0;
            match_cnt_reg  <= '0;
          end
        end
        SHIFT: begin
          shift_reg     <= {shift_reg[WORD_W-2:0], 1'b0};
          bit_cnt_reg   <= bit_cnt_reg + 1'b1;
          match_cnt_reg <= match_cnt_reg + CNT_W'(det_out);
        end
        FLUSH: begin
          // The detector lags one cycle, so this picks up a match that
          // ends on the final bit of the word.
          match_cnt_reg <= match_cnt_reg + CNT_W'(det_out);
          res_count_reg <= match_cnt_reg + CNT_W'(det_out);
          res_id_reg    <= last_grant_reg;
          res_valid_reg <= 1'b1;
        end
        REPORT: begin
          res_valid_reg <= 1'b0;
        end
        default: res_valid_reg <= 1'b0;
      endcase
    end
  end

  det001_moore u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .in  (shift_reg[WORD_W-1]),
    .out (det_out)
  );

  assign res_valid = res_valid_reg;
  assign res_id    = res_id_reg;
  assign res_count = res_count_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed, table-driven bench for seq_det_sched with N_REQ=4, WORD_W=8.
module tb_seq_det_sched;

  localparam int N_REQ  = 4;
  localparam int WORD_W = 8;
  localparam int ID_W   = 2;
  localparam int CNT_W  = 4;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    res_valid;
  logic [ID_W-1:0]         res_id;
  logic [CNT_W-1:0]        res_count;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cnt;
  } vec_t;

  vec_t vecs [8];

  seq_det_sched #(
    .N_REQ  (N_REQ),
    .WORD_W (WORD_W),
    .ID_W   (ID_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_count (res_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction starting in the grant cycle T: checks the ready pulse,
  // busy and quiet outputs through T+9, the result at T+10, and IDLE at T+11.
  task automatic run_txn(input int id, input int cnt, input bit drop);
    logic [31:0] exp_rdy;
    exp_rdy = 32'(1) << id;
    #1;
    chk("ready_grant", 32'(req_ready), exp_rdy);
    step();
    if (drop) req_valid = '0;
    for (int k = 1; k <= 9; k++) begin
      chk("busy_active", 32'(busy), 1);
      chk("res_valid_early", 32'(res_valid), 0);
      chk("ready_while_busy", 32'(req_ready), 0);
      step();
    end
    chk("res_valid_at_T10", 32'(res_valid), 1);
    chk("res_id", 32'(res_id), 32'(id));
    chk("res_count", 32'(res_count), 32'(cnt));
    chk("busy_report", 32'(busy), 1);
    $display("txn id=%0d res_id=%0d res_count=%0d expected_count=%0d", id, res_id, res_count, cnt);
    step();
    chk("res_valid_after", 32'(res_valid), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{id: 2, data: 8'b0010_0100, cnt: 2};
    vecs[1] = '{id: 0, data: 8'b1111_1001, cnt: 1};
    vecs[2] = '{id: 3, data: 8'h00,        cnt: 0};
    vecs[3] = '{id: 1, data: 8'b1111_1100, cnt: 0};
    vecs[4] = '{id: 1, data: 8'b1111_1111, cnt: 0};
    vecs[5] = '{id: 3, data: 8'b0000_0001, cnt: 1};
    vecs[6] = '{id: 0, data: 8'b1001_0010, cnt: 2};
    vecs[7] = '{id: 2, data: 8'b0100_1001, cnt: 2};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    #2;
    rst = 1'b0;

    // Reset held with every requester valid: nothing may be granted.
    req_valid = 4'hF;
    req_data[0*8 +: 8] = 8'b0010_0100;
    req_data[1*8 +: 8] = 8'b1111_1001;
    req_data[2*8 +: 8] = 8'h00;
    req_data[3*8 +: 8] = 8'b0100_1001;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_res_count", 32'(res_count), 0);
    rst = 1'b1;
    $display("reset released with req_valid=%b", req_valid);

    // Round-robin with all requesters held valid: grants 0,1,2,3,0.
    run_txn(0, 2, 1'b0);
    run_txn(1, 1, 1'b0);
    run_txn(2, 0, 1'b0);
    run_txn(3, 2, 1'b0);
    run_txn(0, 2, 1'b1);

    // Single-requester vectors.
    for (int v = 0; v < 8; v++) begin
      req_data[vecs[v].id*8 +: 8] = vecs[v].data;
      req_valid = 4'(1 << vecs[v].id);
      run_txn(vecs[v].id, vecs[v].cnt, 1'b1);
    end

    // Reset in the middle of SHIFT: aborts with no result, restores priority.
    req_data[1*8 +: 8] = 8'b0010_0100;
    req_valid = 4'b0010;
    #1;
    chk("midrst_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    step();
    step();
    chk("midrst_busy_before", 32'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_res_id", 32'(res_id), 0);
    chk("midrst_res_count", 32'(res_count), 0);
    for (int c = 0; c < 8; c++) begin
      step();
      chk("midrst_no_result", 32'(res_valid), 0);
      chk("midrst_idle", 32'(busy), 0);
    end
    req_valid = 4'b1010;
    req_data[3*8 +: 8] = 8'hFF;
    rst = 1'b1;
    $display("reset released mid-test with req_valid=%b", req_valid);
    run_txn(1, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
